// File: rtl/run_detect.sv
// Multi-channel run-length detector with Mealy and Moore outputs, sample-enable gating and polarity select.
// Define RUN_DETECT_HIT_CNT_EN to build the per-channel saturating hit counters; otherwise hit_cnt is tied to 0.
module run_detect #(
  parameter int RUN_LEN  = 4,
  parameter int CHANNELS = 1,
  parameter int HIT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CHANNELS-1:0]         w,
  input  logic [1:0]                  mode,
  output logic [CHANNELS-1:0]         z_mealy,
  output logic [CHANNELS-1:0]         z_moore,
  output logic [CHANNELS*HIT_W-1:0]   hit_cnt
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(RUN_LEN - 1);

  function automatic logic pol_ok(input logic b, input logic [1:0] m);
    case (m)
      2'b00:   return 1'b1;
      2'b01:   return b;
      2'b10:   return ~b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] seen_p1;
  logic [CHANNELS-1:0] last_p1;
  logic [CNT_W-1:0]    cnt_p1 [CHANNELS];

  // Stage 1: per-channel run state, advanced only on accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_p1 <= '0;
      last_p1 <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= '0;
    end else if (en) begin
      seen_p1 <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!seen_p1[i] || (w[i] != last_p1[i])) begin
          last_p1[i] <= w[i];
          cnt_p1[i]  <= CNT_W'(1);
        end else begin
          cnt_p1[i]  <= sat_inc_cnt(cnt_p1[i]);
        end
      end
    end
  end

  always_comb begin
    z_moore = '0;
    z_mealy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      z_moore[i] = (cnt_p1[i] == CNT_MAX) && pol_ok(last_p1[i], mode);
      z_mealy[i] = en && seen_p1[i] && (w[i] == last_p1[i]) &&
                   (cnt_p1[i] >= CNT_ARM) && pol_ok(w[i], mode);
    end
  end

`ifdef RUN_DETECT_HIT_CNT_EN
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  function automatic logic [HIT_W-1:0] sat_inc_hit(input logic [HIT_W-1:0] h);
    return (h == HIT_MAX) ? HIT_MAX : h + HIT_W'(1);
  endfunction

  logic [CHANNELS-1:0] moore_p2;
  logic [HIT_W-1:0]    hit_p2 [CHANNELS];

  // Stage 2: a rising z_moore is seen as high now while low in the previous cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      moore_p2 <= '0;
      for (int i = 0; i < CHANNELS; i++) hit_p2[i] <= '0;
    end else begin
      moore_p2 <= z_moore;
      for (int i = 0; i < CHANNELS; i++) begin
        if (z_moore[i] && !moore_p2[i]) hit_p2[i] <= sat_inc_hit(hit_p2[i]);
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) hit_cnt[i*HIT_W +: HIT_W] = hit_p2[i];
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: doc/run_detect.md
# run_detect

Parametrised run-length detector, the successor to the fixed four-in-a-row Mealy/Moore pair driven by the `top` harness. Each of `CHANNELS` independent serial inputs is watched for `RUN_LEN` consecutive equal samples, with the result reported two ways:

- a Mealy output, asserted in the cycle the qualifying sample is presented;
- a Moore output, asserted one cycle later from registered state.

It adds sample-enable gating, polarity selection and an optional per-channel hit counter. It sits directly behind the board-level switch/input sampling and drives LEDs or downstream control.

## Interface

- `RUN_LEN`, 4, number of consecutive equal samples that constitutes a run; legal range 2..255.
- `CHANNELS`, 1, number of independent detector channels; legal range 1..16.
- `HIT_W`, 8, width of each per-channel hit counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: sample strobe; `w` is consumed only in cycles with `en`=1.
- `w` input CHANNELS: one serial data bit per channel.
- `mode` input 2: polarity select.
  - 00: runs of 0 or 1
  - 01: runs of 1 only
  - 10: runs of 0 only
  - 11: detection disabled
- `z_mealy` output CHANNELS: per-channel Mealy detection (combinational).
- `z_moore` output CHANNELS: per-channel Moore detection (registered-state decode).
- `hit_cnt` output CHANNELS*HIT_W: packed per-channel hit counters; channel i occupies bits [i*HIT_W +: HIT_W].

## Operation

- **Per-channel state**
  - `seen`: 1 bit, set by the first accepted sample.
  - `last`: 1 bit, the value of the current run.
  - `cnt`: width `$clog2(RUN_LEN+1)`, range 0..RUN_LEN, saturating.
- **Update on a cycle with `en`=1**, per channel:
  - If `seen`=0 or `w`≠`last`: `last`←`w`, `cnt`←1.
  - Otherwise `cnt`←min(`cnt`+1, RUN_LEN).
  - `seen`←1.
- **`en`=0:** all state holds. Idle cycles do not break a run.
- **`pol_ok(b)`:**
  - mode 00: 1
  - mode 01: b==1
  - mode 10: b==0
  - mode 11: 0
- **`z_moore[i]`** = (`cnt`==RUN_LEN) && pol_ok(`last`).
- **`z_mealy[i]`** = `en` && `seen` && (`w`==`last`) && (`cnt`≥RUN_LEN−1) && pol_ok(`w`).
- **Overlap:**
  - A run longer than RUN_LEN keeps both outputs asserted for every further equal sample.
  - A changed sample starts a new run of length 1; there is no re-arm gap.
- **`mode`:** quasi-static configuration, changed only while `en`=0. It is applied combinationally to both outputs and does not affect `cnt`/`last`.
- **Runs of different lengths:** a run of RUN_LEN zeros followed by RUN_LEN ones yields two separate detections.

## Timing

- **Reset:** `rst`=1 at a rising edge clears `seen`, `last`, `cnt` and `hit_cnt` to 0.
  - `z_moore`=0 from the following cycle.
  - `z_mealy`=0 in the cycle after reset, since `seen`=0.
  - Reset mid-run discards the run; a full RUN_LEN fresh samples are needed afterwards.
- **Reset and `en` together:** reset wins over `en` in the same cycle; the sample is dropped.
- **Mealy latency:** 0 cycles; `z_mealy` is high in the cycle the RUN_LEN-th equal sample is on `w` with `en`=1.
- **Moore latency:** 1 cycle; `z_moore` rises on the clock edge that accepts the RUN_LEN-th sample. It stays high until a differing sample is accepted, and falls on that edge.
- **No combinational path** from `w`, `en` or `mode` to any register other than through the defined state update. `z_mealy` depends combinationally on `w`, `en` and `mode`.
- **Channels are fully independent.** They share only `clk`, `rst`, `en` and `mode`.

## Configuration

- **`RUN_DETECT_HIT_CNT_EN` defined:** per channel, `hit_cnt` increments by 1 on each rising edge of `z_moore[i]` (0→1 between consecutive cycles).
  - Saturates at 2^HIT_W−1.
  - Cleared only by `rst`.
- **Not defined:** the counters are not built and `hit_cnt` is tied to 0. The port remains present so instantiations are unchanged.

## Test plan

All scenarios use RUN_LEN=4, CHANNELS=2, macro defined unless stated.

- **Basic run:** reset, then `en`=1 with `w[0]`=0,0,0,0 → `z_mealy[0]`=1 in the 4th sample cycle, `z_moore[0]`=1 from the next cycle, `hit_cnt[0]`=1.
- **Extended run then break:** continue with 0,0,1 → both outputs stay 1 for the two extra 0s. `z_mealy[0]`=0 in the 1 cycle; `z_moore[0]` falls on that edge.
- **Enable gating:** sequence 1,1,(en=0 ×3),1,1 → detection on the 4th accepted sample; `z_mealy`=0 throughout the `en`=0 cycles.
- **Polarity:** `mode`=01 with 0000 on ch0 and 1111 on ch1 → only ch1 asserts. `mode`=11 → neither asserts, yet `cnt` is 4 on both (verified by switching to 00 and seeing `z_moore`=11 immediately).
- **Reset mid-run:** 1,1,1, `rst`, 1 → no detection; the fourth post-reset 1 is required. `hit_cnt` returns to 0.
- **Macro off / saturation:**
  - With `RUN_DETECT_HIT_CNT_EN` undefined, repeated runs → `hit_cnt`=0.
  - With it defined and HIT_W=2, five separated runs → `hit_cnt`=3.
